// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among NUM_REQ byte
// producers: captures the winning byte, launches a frame, holds tx_din and spaces frames.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WD      = 8,
    parameter int GAP_CYCLES   = 0,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0] req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [DATA_WD-1:0]         tx_din,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       frame_done,
    output logic                       timeout_err
);

    localparam int ID_WD = $clog2(NUM_REQ);
    localparam int PW    = ID_WD + 1;
    localparam int TO_WD = $clog2(BUSY_TIMEOUT) + 1;

    localparam logic [ID_WD-1:0] LAST_RST = ID_WD'(NUM_REQ - 1);
    localparam logic [PW-1:0]    POS_WRAP = PW'(NUM_REQ);
    localparam logic [TO_WD-1:0] TO_LAST  = TO_WD'(BUSY_TIMEOUT - 1);
    localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    state_t               state_r;
    logic [ID_WD-1:0]     last_r;
    logic [TO_WD-1:0]     to_cnt_r;
    logic [7:0]           gap_cnt_r;
    logic                 tx_start_r;
    logic [DATA_WD-1:0]   tx_din_r;
    logic [ID_WD-1:0]     grant_id_r;
    logic                 active_r;
    logic                 frame_done_r;
    logic                 timeout_err_r;

    logic [PW-1:0]        pos_s;
    logic                 win_vld_s;
    logic [ID_WD-1:0]     win_id_s;
    logic [DATA_WD-1:0]   win_data_s;
    logic [NUM_REQ-1:0]   ready_s;
    logic                 accept_s;

    // Rotating search: first valid requester strictly after the previous winner.
    always_comb begin
        win_vld_s = 1'b0;
        win_id_s  = '0;
        pos_s     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos_s     = {1'b0, last_r} + PW'(k);
            pos_s     = (pos_s >= POS_WRAP) ? (pos_s - POS_WRAP) : pos_s;
            win_id_s  = (!win_vld_s && req_valid[pos_s[ID_WD-1:0]]) ? pos_s[ID_WD-1:0] : win_id_s;
            win_vld_s = win_vld_s | req_valid[pos_s[ID_WD-1:0]];
        end
    end

    // Byte of the current winner.
    always_comb begin
        win_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_data_s = (win_id_s == ID_WD'(i)) ? req_data[i*DATA_WD +: DATA_WD] : win_data_s;
        end
    end

    // One-hot ready for the winner, offered only while idle.
    always_comb begin
        ready_s = '0;
        if ((state_r == ST_IDLE) && win_vld_s) begin
            ready_s[win_id_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign accept_s = |(req_valid & ready_s);

    // Frame sequencer; every output except req_ready comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            last_r        <= LAST_RST;
            to_cnt_r      <= '0;
            gap_cnt_r     <= 8'd0;
            tx_start_r    <= 1'b0;
            tx_din_r      <= '0;
            grant_id_r    <= '0;
            active_r      <= 1'b0;
            frame_done_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            tx_start_r    <= 1'b0;
            frame_done_r  <= 1'b0;
            timeout_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        tx_din_r   <= win_data_s;
                        grant_id_r <= win_id_s;
                        last_r     <= win_id_s;
                        tx_start_r <= 1'b1;
                        active_r   <= 1'b1;
                        state_r    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    to_cnt_r <= '0;
                    state_r  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    // Fire on the edge where the count would reach its terminal value so
                    // the registered pulse lands BUSY_TIMEOUT cycles after tx_start.
                    if (tx_busy) begin
                        state_r <= ST_WAIT_DONE;
                    end else if ((to_cnt_r + TO_WD'(1)) >= TO_LAST) begin
                        timeout_err_r <= 1'b1;
                        gap_cnt_r     <= 8'd0;
                        state_r       <= ST_GAP;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_WD'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        frame_done_r <= 1'b1;
                        gap_cnt_r    <= 8'd0;
                        state_r      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r >= GAP_LAST) begin
                        active_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 8'd1;
                    end
                end
                default: begin
                    active_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = ready_s;
    assign tx_start    = tx_start_r;
    assign tx_din      = tx_din_r;
    assign grant_id    = grant_id_r;
    assign active      = active_r;
    assign frame_done  = frame_done_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small 1-clock-per-bit UART transmitter model.
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int GAP   = 2;
    localparam int BTO   = 16;
    localparam int FRAME = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            tx_busy;
    logic            tx_start;
    logic [DW-1:0]   tx_din;
    logic [1:0]      grant_id;
    logic            active;
    logic            frame_done;
    logic            timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_WD(DW), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BTO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_din(tx_din),
        .grant_id(grant_id), .active(active),
        .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter model: start bit, 8 data bits LSB-first, stop bit; busy for 10 cycles.
    logic       busy_en;
    logic       m_busy;
    logic [3:0] m_bit;
    logic [9:0] m_sh;
    logic       tx_line;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_bit  <= 4'd0;
            m_sh   <= 10'h3FF;
        end else if (!m_busy) begin
            if (tx_start && busy_en) begin
                m_busy <= 1'b1;
                m_sh   <= {1'b1, tx_din, 1'b0};
                m_bit  <= 4'd0;
            end
        end else begin
            m_bit <= m_bit + 4'd1;
            if (m_bit == 4'd9) m_busy <= 1'b0;
        end
    end

    assign tx_busy = m_busy;
    assign tx_line = m_busy ? m_sh[m_bit] : 1'b1;

    int         cyc = 0;
    int         n_start = 0, n_done = 0, n_to = 0, n_rx = 0;
    int         done_cyc = 0, to_cyc = 0;
    int         start_cyc [32];
    logic [1:0] log_gid [32];
    logic [7:0] log_din [32];
    logic [9:0] rx_sh = 10'h0;
    logic [7:0] rx_byte = 8'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge.
    always @(negedge clk) begin
        if (tx_start) begin
            if (n_start < 32) begin
                start_cyc[n_start] <= cyc;
                log_gid[n_start]   <= grant_id;
                log_din[n_start]   <= tx_din;
            end
            n_start <= n_start + 1;
        end
        if (frame_done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (timeout_err) begin
            n_to   <= n_to + 1;
            to_cyc <= cyc;
        end
        if (m_busy) begin
            rx_sh <= {tx_line, rx_sh[9:1]};
            if (m_bit == 4'd9) begin
                rx_byte <= rx_sh[9:2];
                n_rx    <= n_rx + 1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_starts(input string tag, input int target, input int budget);
        int k = 0;
        while (n_start < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(tag, n_start, target);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (active && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(tag, {31'd0, active}, 32'd0);
    endtask

    task automatic hold_check(input string tag, input logic [7:0] din, input logic [1:0] gid,
                              input int done_target, input bit scramble);
        int k = 0;
        while (n_done < done_target && k < 40) begin
            if (scramble) req_data = $urandom;
            chk({tag, "_din"}, tx_din, din);
            chk({tag, "_gid"}, grant_id, gid);
            @(negedge clk); #1;
            k++;
        end
        chk({tag, "_done"}, n_done, done_target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d tests, want completion", n_tests);
        $fatal(1);
    end

    initial begin
        int base, dbase, tbase, k;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        busy_en   = 1'b1;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_din", tx_din, 8'h00);
        chk("rst_grant_id", grant_id, 2'd0);
        chk("rst_active", active, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_ready_none", req_ready, 4'b0000);
        req_valid = 4'b1010; #1;
        chk("rst_ready_prio", req_ready, 4'b0010);
        req_valid = 4'b0000;
        @(negedge clk); rst = 1'b0;

        // Single request from requester 2.
        @(negedge clk); #1;
        base  = n_start;
        dbase = n_done;
        req_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
        req_valid = 4'b0100; #1;
        chk("t1_ready", req_ready, 4'b0100);
        @(negedge clk); #1;
        chk("t1_tx_start", tx_start, 1'b1);
        chk("t1_active", active, 1'b1);
        chk("t1_ready_off", req_ready, 4'b0000);
        req_valid = 4'b0000;
        hold_check("t1_hold", 8'hA5, 2'd2, dbase + 1, 1'b0);
        chk("t1_done_lat", done_cyc - start_cyc[base], FRAME + 2);
        wait_idle("t1_idle", 40);
        chk("t1_start_cnt", n_start - base, 1);
        chk("t1_serial", rx_byte, 8'hA5);

        // Pointer wrap: requester 3 alone, then 0 and 3 together.
        base = n_start;
        req_data  = {8'h3C, 8'h00, 8'h00, 8'h00};
        req_valid = 4'b1000;
        wait_starts("wrap_s1", base + 1, 40);
        req_valid = 4'b0000;
        wait_idle("wrap_idle1", 40);
        req_data  = {8'h3D, 8'h00, 8'h00, 8'hC0};
        req_valid = 4'b1001;
        wait_starts("wrap_s2", base + 2, 40);
        req_valid = 4'b1000;
        wait_starts("wrap_s3", base + 3, 40);
        req_valid = 4'b0000;
        wait_idle("wrap_idle2", 40);
        chk("wrap_gid0", log_gid[base], 2'd3);
        chk("wrap_gid1", log_gid[base + 1], 2'd0);
        chk("wrap_din1", log_din[base + 1], 8'hC0);
        chk("wrap_gid2", log_gid[base + 2], 2'd3);
        chk("wrap_din2", log_din[base + 2], 8'h3D);

        // Fairness with all four requesters continuously valid.
        base  = n_start;
        dbase = n_done;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        wait_starts("fair_starts", base + 5, 120);
        req_valid = 4'b0000;
        wait_idle("fair_idle", 40);
        for (int i = 0; i < 5; i++) begin
            chk("fair_gid", log_gid[base + i], 32'(i % 4));
            chk("fair_din", log_din[base + i], 32'(8'h10 + i % 4));
        end
        for (int i = 1; i < 5; i++) begin
            chk("fair_spacing", start_cyc[base + i] - start_cyc[base + i - 1], FRAME + GAP + 4);
        end
        chk("fair_done_cnt", n_done - dbase, 5);

        // Timeout: transmitter never goes busy for requester 1, then requester 2 proceeds.
        base  = n_start;
        dbase = n_done;
        tbase = n_to;
        busy_en   = 1'b0;
        req_data  = {8'h00, 8'h66, 8'h55, 8'h00};
        req_valid = 4'b0110;
        wait_starts("to_s1", base + 1, 40);
        req_valid = 4'b0100;
        chk("to_gid", log_gid[base], 2'd1);
        k = 0;
        while (n_to < tbase + 1 && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        chk("to_seen", n_to, tbase + 1);
        chk("to_latency", to_cyc - start_cyc[base], BTO);
        chk("to_no_done", n_done - dbase, 0);
        busy_en = 1'b1;
        wait_starts("to_s2", base + 2, 40);
        req_valid = 4'b0000;
        chk("to_next_gid", log_gid[base + 1], 2'd2);
        chk("to_next_lat", start_cyc[base + 1] - start_cyc[base], BTO + GAP + 2);
        wait_idle("to_idle", 40);
        chk("to_pulse_cnt", n_to - tbase, 1);
        chk("to_done_after", n_done - dbase, 1);

        // Reset asserted while waiting for the frame to finish.
        base  = n_start;
        dbase = n_done;
        req_data  = {8'h00, 8'h00, 8'h00, 8'h77};
        req_valid = 4'b0001;
        wait_starts("rm_s1", base + 1, 40);
        req_valid = 4'b0000;
        repeat (4) @(negedge clk);
        #1;
        chk("rm_busy_before", tx_busy, 1'b1);
        req_valid = 4'b1111;
        rst = 1'b1; #1;
        chk("rm_tx_start", tx_start, 1'b0);
        chk("rm_tx_din", tx_din, 8'h00);
        chk("rm_grant_id", grant_id, 2'd0);
        chk("rm_active", active, 1'b0);
        chk("rm_frame_done", frame_done, 1'b0);
        chk("rm_timeout_err", timeout_err, 1'b0);
        chk("rm_ready", req_ready, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_starts("rm_s2", base + 2, 20);
        req_valid = 4'b0000;
        chk("rm_first_gid", log_gid[base + 1], 2'd0);
        chk("rm_no_done", n_done - dbase, 0);
        wait_idle("rm_idle", 40);

        // Data stability: requester data scrambled every cycle during the frame.
        base  = n_start;
        dbase = n_done;
        req_data  = {8'h00, 8'h96, 8'h00, 8'h00};
        req_valid = 4'b0100;
        wait_starts("st_s1", base + 1, 40);
        req_valid = 4'b0000;
        hold_check("st_hold", 8'h96, 2'd2, dbase + 1, 1'b1);
        chk("st_serial", rx_byte, 8'h96);
        wait_idle("st_idle", 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among `NUM_REQ` byte producers. It accepts one byte at a time from the winning requester and launches a frame on the transmitter. It then holds the transmitter's data input stable until the frame completes and enforces a programmable inter-frame gap. It sits between the client logic (command engine, status reporter, debug port) and the single `uart_tx` instance.

## Interface

**Parameters**
- `NUM_REQ`, 4, number of requesters (2..8).
- `DATA_WD`, 8, byte width; must match the transmitter's data width.
- `GAP_CYCLES`, 0, idle clk cycles inserted after each frame before the next grant (0..255).
- `BUSY_TIMEOUT`, 16, clk cycles allowed between `tx_start` and the transmitter asserting `tx_busy`.

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: bit i high means requester i presents a byte.
- `req_data` in NUM_REQ*DATA_WD: byte of requester i at bits [i*DATA_WD +: DATA_WD].
- `req_ready` out NUM_REQ: one-hot, combinational; byte i is accepted on a clk edge where `req_valid[i] && req_ready[i]`.
- `tx_busy` in 1: transmitter busy flag.
- `tx_start` out 1: one-cycle launch pulse to the transmitter.
- `tx_din` out DATA_WD: byte to the transmitter; held constant for the whole frame.
- `grant_id` out clog2(NUM_REQ): index of the requester owning the current frame.
- `active` out 1: high from acceptance until return to IDLE.
- `frame_done` out 1: one-cycle pulse when the transmitter finishes a frame.
- `timeout_err` out 1: one-cycle pulse when `tx_busy` is not seen within `BUSY_TIMEOUT`.

## Operation

- State register is clocked on `clk` and cleared by async `rst`. States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- **Round-robin pointer `last`** (reset value NUM_REQ-1):
  - Search order is last+1, last+2, … modulo NUM_REQ.
  - After reset, requester 0 has top priority.
  - `last` updates to the winner on acceptance.
- **IDLE**:
  - `req_ready` = one-hot winner among `req_valid`; 0 if none valid.
  - On acceptance, the edge captures the winner's byte into `tx_din`, captures the index into `grant_id`, and moves to LAUNCH.
- **LAUNCH**:
  - `tx_start`=1 for exactly this cycle.
  - Clear the timeout counter and go to WAIT_BUSY.
- **WAIT_BUSY**:
  - On `tx_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches BUSY_TIMEOUT-1, pulse `timeout_err`, abandon the frame (no `frame_done`), and go to GAP.
- **WAIT_DONE**:
  - On `tx_busy`=0, pulse `frame_done` and go to GAP.
- **GAP**:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - When GAP_CYCLES=0, GAP lasts exactly 1 cycle.
- **Outputs while not IDLE**:
  - `req_ready`=0.
  - `tx_din` and `grant_id` hold their captured values through GAP.
  - New `req_valid`/`req_data` changes are ignored.
- `active`=1 in every state except IDLE.
- Counter widths: timeout counter clog2(BUSY_TIMEOUT)+1 bits; gap counter 8 bits. Neither counter wraps: each saturates or exits the state at its terminal value.
- A requester that drops `req_valid` before being granted loses its turn with no side effects.

## Timing

- **Reset values**:
  - `req_ready`=0 unless a requester is valid, since it is combinational in IDLE.
  - `tx_start`=0, `tx_din`=0, `grant_id`=0, `active`=0, `frame_done`=0, `timeout_err`=0.
  - State = IDLE, `last`=NUM_REQ-1.
- **Launch latency**: acceptance edge at cycle T gives `tx_start`=1 during cycle T+1. `tx_din` is valid from T+1.
- **Busy detection**: with a transmitter that raises `tx_busy` one cycle after `tx_start`, WAIT_BUSY lasts 1 cycle.
- **Frame end**: `frame_done` is high in the cycle after the first cycle `tx_busy` is sampled 0 in WAIT_DONE.
- **Minimum grant-to-grant spacing**: frame length + GAP_CYCLES + 4 cycles.
- **Simultaneous valid**: exactly one grant per IDLE visit, strictly rotating. With all requesters continuously valid, the grant order is 0,1,2,3,0,…
- **Reset mid-frame**: all outputs return to reset values asynchronously; no `frame_done` is generated. The transmitter is reset by the same `rst`.

## Test plan

- **Single request**: `req_valid`=4'b0100, byte 0xA5.
  - `req_ready`=4'b0100 for one cycle; `tx_start` pulses once; `tx_din`=0xA5 and `grant_id`=2 held until `frame_done`.
  - The serial line shows 0xA5 LSB-first.
- **Fairness**: all four requesters valid, bytes 0x10..0x13, GAP_CYCLES=2.
  - Grants in order 0,1,2,3,0; `frame_done` count equals `tx_start` count.
  - Each consecutive pair of `tx_start` pulses is at least frame+6 cycles apart.
- **Pointer wrap**: only requester 3 valid for one frame, then requesters 0 and 3 valid.
  - Next grant is 0, then 3.
- **Timeout**: `tx_busy` tied 0, BUSY_TIMEOUT=16.
  - `timeout_err` pulses exactly 16 cycles after `tx_start`; no `frame_done`; the arbiter returns to IDLE and grants the next requester.
- **Reset mid-frame**: assert `rst` during WAIT_DONE.
  - All outputs go to reset values immediately.
  - After release with `req_valid`=4'b1111, the first grant is requester 0.
- **Data stability**: change `req_data` of the granted requester every cycle during the frame.
  - `tx_din` and the serial output remain the byte captured at acceptance.
